// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point datapath blocks: FSM states,
// flag bit positions, exponent bias and the canonical NaN pattern.
package fp_pkg;

  typedef enum logic [3:0] {
    GET_A,
    GET_B,
    UNPACK,
    SPECIAL,
    ALIGN,
    ADD,
    NORM,
    ROUND,
    PACK,
    PUT_Z
  } fp_state_t;

  localparam int FLAG_INVALID  = 2;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_INEXACT  = 0;

  localparam int GRS_W     = 3;
  localparam int NAN_MAX_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Sign 1, exponent all ones, fraction MSB set; callers truncate to their width.
  function automatic logic [NAN_MAX_W-1:0] fp_canon_nan(input int exp_w, input int man_w);
    logic [NAN_MAX_W-1:0] v;
    v = '0;
    v[exp_w + man_w] = 1'b1;
    for (int i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even, overflow detection and IEEE packing of a normalised
// mantissa; purely combinational so other FP operators can share it.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                      sign_i,
  input  logic signed [EXP_W+2:0]   exp_i,
  input  logic [MAN_W+3:0]          man_i,
  output logic [EXP_W+MAN_W:0]      z_o,
  output logic [2:0]                flags_o
);

  localparam int XW = EXP_W + 3;
  localparam logic signed [XW-1:0] BIAS_X = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);

  logic                   inexact;
  logic                   round_up;
  logic [MAN_W+1:0]       rounded;
  logic                   hidden;
  logic [MAN_W-1:0]       frac;
  logic signed [XW-1:0]   exp_r;
  logic signed [XW-1:0]   biased;

  // A subnormal whose rounding sets the hidden bit naturally becomes exponent field 1.
  always_comb begin
    inexact  = man_i[2] | man_i[1] | man_i[0];
    round_up = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
    rounded  = {1'b0, man_i[MAN_W+3:GRS_W]} + {{(MAN_W+1){1'b0}}, round_up};
    hidden   = rounded[MAN_W];
    frac     = rounded[MAN_W-1:0];
    exp_r    = exp_i;
    if (rounded[MAN_W+1]) begin
      hidden = 1'b1;
      frac   = rounded[MAN_W:1];
      exp_r  = exp_i + ONE_X;
    end
    biased  = hidden ? (exp_r + BIAS_X) : '0;
    flags_o = '0;
    if (biased >= EMAX_X) begin
      z_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_o[FLAG_OVERFLOW] = 1'b1;
      flags_o[FLAG_INEXACT]  = 1'b1;
    end else begin
      z_o = {sign_i, biased[EXP_W-1:0], frac};
      flags_o[FLAG_INEXACT] = inexact;
    end
  end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle IEEE-style floating-point adder/subtractor with stb/ack
// handshakes on both operands and the result.
module fp_addsub
  import fp_pkg::*;
#(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic                 input_a_stb,
  output logic                 input_a_ack,
  input  logic [EXP_W+MAN_W:0] input_b,
  input  logic                 input_b_stb,
  output logic                 input_b_ack,
  input  logic                 input_op,
  output logic [EXP_W+MAN_W:0] output_z,
  output logic                 output_z_stb,
  input  logic                 output_z_ack,
  output logic [2:0]           output_flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int XW = EXP_W + 3;
  localparam int MW = MAN_W + 1 + GRS_W;
  localparam int SB = EXP_W + MAN_W;

  localparam logic signed [XW-1:0] BIAS_X    = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] EMIN_X    = XW'(1 - fp_bias(EXP_W));
  localparam logic signed [XW-1:0] ONE_X     = XW'(1);
  localparam logic signed [XW-1:0] SHIFT_MAX = XW'(MAN_W + 3);
  localparam logic [W-1:0]         CANON_NAN = W'(fp_canon_nan(EXP_W, MAN_W));

  fp_state_t            state_q;
  logic [W-1:0]         a_q, b_q;
  logic                 op_q;
  logic                 a_s_q, b_s_q, z_s_q;
  logic signed [XW-1:0] a_e_q, b_e_q, z_e_q;
  logic [MW-1:0]        a_m_q, b_m_q;
  logic [MW:0]          z_m_q;
  logic [W-1:0]         res_q;
  logic [2:0]           res_flags_q;
  logic                 a_ack_q, b_ack_q, z_stb_q;
  logic [W-1:0]         z_q;
  logic [2:0]           flags_q;

  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [MAN_W-1:0]     a_frac, b_frac;
  logic                 a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [XW-1:0] a_e_un, b_e_un;
  logic [W-1:0]         b_eff;
  logic                 sp_hit;
  logic [W-1:0]         sp_z;
  logic [2:0]           sp_flags;
  logic                 add_s;
  logic [MW:0]          add_m;
  logic [W-1:0]         rp_z;
  logic [2:0]           rp_flags;

  assign a_exp  = a_q[MAN_W +: EXP_W];
  assign b_exp  = b_q[MAN_W +: EXP_W];
  assign a_frac = a_q[MAN_W-1:0];
  assign b_frac = b_q[MAN_W-1:0];
  assign a_nan  = (&a_exp) & (|a_frac);
  assign b_nan  = (&b_exp) & (|b_frac);
  assign a_inf  = (&a_exp) & ~(|a_frac);
  assign b_inf  = (&b_exp) & ~(|b_frac);
  assign a_zero = (a_exp == '0) & (a_frac == '0);
  assign b_zero = (b_exp == '0) & (b_frac == '0);
  assign a_e_un = $signed({{(XW-EXP_W){1'b0}}, a_exp}) - BIAS_X;
  assign b_e_un = $signed({{(XW-EXP_W){1'b0}}, b_exp}) - BIAS_X;
  assign b_eff  = {b_s_q, b_q[SB-1:0]};

  // Operands that bypass the arithmetic path; b_s_q already carries the op inversion.
  always_comb begin
    sp_hit   = 1'b1;
    sp_z     = '0;
    sp_flags = '0;
    if (a_nan || b_nan) begin
      sp_z = CANON_NAN;
    end else if (a_inf && b_inf && (a_s_q != b_s_q)) begin
      sp_z = CANON_NAN;
      sp_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf) begin
      sp_z = a_q;
    end else if (b_inf) begin
      sp_z = b_eff;
    end else if (a_zero && b_zero) begin
      sp_z = {a_s_q & b_s_q, {(W-1){1'b0}}};
    end else if (a_zero) begin
      sp_z = b_eff;
    end else if (b_zero) begin
      sp_z = a_q;
    end else begin
      sp_hit = 1'b0;
    end
  end

  always_comb begin
    add_s = a_s_q;
    if (a_s_q == b_s_q) begin
      add_m = {1'b0, a_m_q} + {1'b0, b_m_q};
    end else if (a_m_q >= b_m_q) begin
      add_m = {1'b0, a_m_q} - {1'b0, b_m_q};
    end else begin
      add_m = {1'b0, b_m_q} - {1'b0, a_m_q};
      add_s = b_s_q;
    end
    if (add_m == '0) add_s = 1'b0;
  end

  fp_round_pack #(
    .EXP_W(EXP_W),
    .MAN_W(MAN_W)
  ) u_round_pack (
    .sign_i  (z_s_q),
    .exp_i   (z_e_q),
    .man_i   (z_m_q[MW-1:0]),
    .z_o     (rp_z),
    .flags_o (rp_flags)
  );

  // Whole operation sequencer; all handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= GET_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      a_s_q       <= 1'b0;
      b_s_q       <= 1'b0;
      z_s_q       <= 1'b0;
      a_e_q       <= '0;
      b_e_q       <= '0;
      z_e_q       <= '0;
      a_m_q       <= '0;
      b_m_q       <= '0;
      z_m_q       <= '0;
      res_q       <= '0;
      res_flags_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      z_stb_q     <= 1'b0;
      z_q         <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        GET_A: begin
          if (a_ack_q && input_a_stb) begin
            a_q     <= input_a;
            a_ack_q <= 1'b0;
            state_q <= GET_B;
          end else begin
            a_ack_q <= 1'b1;
          end
        end
        GET_B: begin
          if (b_ack_q && input_b_stb) begin
            b_q     <= input_b;
            op_q    <= input_op;
            b_ack_q <= 1'b0;
            state_q <= UNPACK;
          end else begin
            b_ack_q <= 1'b1;
          end
        end
        UNPACK: begin
          a_s_q   <= a_q[SB];
          b_s_q   <= b_q[SB] ^ op_q;
          a_e_q   <= (a_exp == '0) ? EMIN_X : a_e_un;
          b_e_q   <= (b_exp == '0) ? EMIN_X : b_e_un;
          a_m_q   <= {a_exp != '0, a_frac, {GRS_W{1'b0}}};
          b_m_q   <= {b_exp != '0, b_frac, {GRS_W{1'b0}}};
          state_q <= SPECIAL;
        end
        SPECIAL: begin
          if (sp_hit) begin
            z_q     <= sp_z;
            flags_q <= sp_flags;
            z_stb_q <= 1'b1;
            state_q <= PUT_Z;
          end else begin
            state_q <= ALIGN;
          end
        end
        ALIGN: begin
          if (a_e_q > b_e_q) begin
            if ((a_e_q - b_e_q) > SHIFT_MAX) begin
              b_m_q <= {{(MW-1){1'b0}}, |b_m_q};
              b_e_q <= a_e_q;
            end else begin
              b_m_q <= {1'b0, b_m_q[MW-1:2], b_m_q[1] | b_m_q[0]};
              b_e_q <= b_e_q + ONE_X;
            end
          end else if (b_e_q > a_e_q) begin
            if ((b_e_q - a_e_q) > SHIFT_MAX) begin
              a_m_q <= {{(MW-1){1'b0}}, |a_m_q};
              a_e_q <= b_e_q;
            end else begin
              a_m_q <= {1'b0, a_m_q[MW-1:2], a_m_q[1] | a_m_q[0]};
              a_e_q <= a_e_q + ONE_X;
            end
          end else begin
            state_q <= ADD;
          end
        end
        ADD: begin
          z_s_q   <= add_s;
          z_e_q   <= a_e_q;
          z_m_q   <= add_m;
          state_q <= NORM;
        end
        NORM: begin
          if (z_m_q[MW]) begin
            z_m_q   <= {1'b0, z_m_q[MW:2], z_m_q[1] | z_m_q[0]};
            z_e_q   <= z_e_q + ONE_X;
            state_q <= ROUND;
          end else if (!z_m_q[MW-1] && (z_e_q > EMIN_X)) begin
            z_m_q <= z_m_q << 1;
            z_e_q <= z_e_q - ONE_X;
          end else begin
            state_q <= ROUND;
          end
        end
        ROUND: begin
          res_q       <= rp_z;
          res_flags_q <= rp_flags;
          state_q     <= PACK;
        end
        PACK: begin
          z_q     <= res_q;
          flags_q <= res_flags_q;
          z_stb_q <= 1'b1;
          state_q <= PUT_Z;
        end
        PUT_Z: begin
          if (output_z_ack) begin
            z_stb_q <= 1'b0;
            state_q <= GET_A;
          end
        end
        default: state_q <= GET_A;
      endcase
    end
  end

  assign input_a_ack  = a_ack_q;
  assign input_b_ack  = b_ack_q;
  assign output_z_stb = z_stb_q;
  assign output_z     = z_q;
  assign output_flags = flags_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub: a double-precision and a single-precision
// instance, hand-computed vectors, backpressure and mid-operation reset.
module tb_fp_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [63:0] a64, b64, z64;
  logic        a64_stb, a64_ack, b64_stb, b64_ack, op64, z64_stb, z64_ack;
  logic [2:0]  fl64;
  logic [31:0] a32, b32, z32;
  logic        a32_stb, a32_ack, b32_stb, b32_ack, op32, z32_stb, z32_ack;
  logic [2:0]  fl32;

  int checks = 0;
  int errors = 0;

  fp_addsub dut64 (
    .clk(clk), .rst(rst),
    .input_a(a64), .input_a_stb(a64_stb), .input_a_ack(a64_ack),
    .input_b(b64), .input_b_stb(b64_stb), .input_b_ack(b64_ack),
    .input_op(op64),
    .output_z(z64), .output_z_stb(z64_stb), .output_z_ack(z64_ack),
    .output_flags(fl64)
  );

  fp_addsub #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst(rst),
    .input_a(a32), .input_a_stb(a32_stb), .input_a_ack(a32_ack),
    .input_b(b32), .input_b_stb(b32_stb), .input_b_ack(b32_ack),
    .input_op(op32),
    .output_z(z32), .output_z_stb(z32_stb), .output_z_ack(z32_ack),
    .output_flags(fl32)
  );

  task automatic send_a(input bit sp, input logic [63:0] v, output bit ok);
    ok = 1'b0;
    if (sp) begin a32 = v[31:0]; a32_stb = 1'b1; end
    else    begin a64 = v;       a64_stb = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      if ((sp ? a32_ack : a64_ack) == 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    a32_stb = 1'b0;
    a64_stb = 1'b0;
  endtask

  task automatic send_b(input bit sp, input logic [63:0] v, input logic op, output bit ok);
    ok = 1'b0;
    if (sp) begin b32 = v[31:0]; op32 = op; b32_stb = 1'b1; end
    else    begin b64 = v;       op64 = op; b64_stb = 1'b1; end
    for (int i = 0; i < 200; i++) begin
      if ((sp ? b32_ack : b64_ack) == 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    b32_stb = 1'b0;
    b64_stb = 1'b0;
  endtask

  task automatic recv_z(input bit sp, output logic [63:0] z, output logic [2:0] fl, output bit ok);
    ok = 1'b0;
    z  = '0;
    fl = '0;
    if (sp) z32_ack = 1'b1; else z64_ack = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if ((sp ? z32_stb : z64_stb) == 1'b1) begin
        z  = sp ? {32'h0, z32} : z64;
        fl = sp ? fl32 : fl64;
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    z32_ack = 1'b0;
    z64_ack = 1'b0;
  endtask

  task automatic run_op(input bit sp, input logic [63:0] a, input logic [63:0] b, input logic op,
                        output logic [63:0] z, output logic [2:0] fl, output bit ok);
    bit ok_a, ok_b, ok_z;
    send_a(sp, a, ok_a);
    send_b(sp, b, op, ok_b);
    recv_z(sp, z, fl, ok_z);
    ok = ok_a & ok_b & ok_z;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({a64_ack, b64_ack, z64_stb} !== 3'b000 || z64 !== 64'h0 || fl64 !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_state64 ack_a/ack_b/stb=%b z=%h flags=%b required 000 0 000",
               {a64_ack, b64_ack, z64_stb}, z64, fl64);
    end
    checks++;
    if ({a32_ack, b32_ack, z32_stb} !== 3'b000 || z32 !== 32'h0 || fl32 !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_state32 ack_a/ack_b/stb=%b z=%h flags=%b required 000 0 000",
               {a32_ack, b32_ack, z32_stb}, z32, fl32);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (a64_ack !== 1'b1 || a32_ack !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ack a64=%b a32=%b required 1 1", a64_ack, a32_ack);
    end
  endtask

  task automatic test_add_basic();
    logic [63:0] z; logic [2:0] fl; bit ok;
    run_op(0, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z !== 64'h4008000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL add_1_2 ok=%0d z=%h flags=%b required 4008000000000000 000", ok, z, fl);
    end
    run_op(0, 64'h4000000000000000, 64'h3FF0000000000000, 1'b1, z, fl, ok);
    checks++;
    if (!ok || z !== 64'h3FF0000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL sub_2_1 ok=%0d z=%h flags=%b required 3FF0000000000000 000", ok, z, fl);
    end
  endtask

  task automatic test_zero_sign();
    logic [63:0] z; logic [2:0] fl; bit ok;
    run_op(0, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, z, fl, ok);
    checks++;
    if (!ok || z !== 64'h0000000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL sub_1_1 ok=%0d z=%h flags=%b required 0000000000000000 000", ok, z, fl);
    end
    run_op(0, 64'h8000000000000000, 64'h8000000000000000, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z !== 64'h8000000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL neg0_neg0 ok=%0d z=%h flags=%b required 8000000000000000 000", ok, z, fl);
    end
    run_op(0, 64'h0000000000000000, 64'hC000000000000000, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z !== 64'hC000000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL zero_plus_m2 ok=%0d z=%h flags=%b required C000000000000000 000", ok, z, fl);
    end
  endtask

  task automatic test_overflow();
    logic [63:0] z; logic [2:0] fl; bit ok;
    run_op(0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z !== 64'h7FF0000000000000 || fl !== 3'b011) begin
      errors++;
      $display("[TB] FAIL overflow ok=%0d z=%h flags=%b required 7FF0000000000000 011", ok, z, fl);
    end
  endtask

  task automatic test_special();
    logic [63:0] z; logic [2:0] fl; bit ok;
    run_op(0, 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1, z, fl, ok);
    checks++;
    if (!ok || z !== 64'hFFF8000000000000 || fl !== 3'b100) begin
      errors++;
      $display("[TB] FAIL inf_minus_inf ok=%0d z=%h flags=%b required FFF8000000000000 100", ok, z, fl);
    end
    run_op(0, 64'h7FF0000000000001, 64'h3FF0000000000000, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z !== 64'hFFF8000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL nan_input ok=%0d z=%h flags=%b required FFF8000000000000 000", ok, z, fl);
    end
    run_op(0, 64'h3FF0000000000000, 64'h7FF0000000000000, 1'b1, z, fl, ok);
    checks++;
    if (!ok || z !== 64'hFFF0000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL one_minus_inf ok=%0d z=%h flags=%b required FFF0000000000000 000", ok, z, fl);
    end
  endtask

  task automatic test_single();
    logic [63:0] z; logic [2:0] fl; bit ok;
    run_op(1, 64'h3F800000, 64'h33800000, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z[31:0] !== 32'h3F800000 || fl !== 3'b001) begin
      errors++;
      $display("[TB] FAIL sp_tie_even ok=%0d z=%h flags=%b required 3F800000 001", ok, z[31:0], fl);
    end
    run_op(1, 64'h00000001, 64'h00000001, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z[31:0] !== 32'h00000002 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL sp_subnormal ok=%0d z=%h flags=%b required 00000002 000", ok, z[31:0], fl);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] z; logic [2:0] fl; bit ok_a, ok_b, ok_z, seen;
    send_a(0, 64'h3FF0000000000000, ok_a);
    send_b(0, 64'h4000000000000000, 1'b0, ok_b);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (z64_stb) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!(ok_a && ok_b && seen)) begin
      errors++;
      $display("[TB] FAIL bp_result_ready ok_a=%0d ok_b=%0d stb_seen=%0d required 1 1 1", ok_a, ok_b, seen);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (z64_stb !== 1'b1 || z64 !== 64'h4008000000000000 || fl64 !== 3'b000) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle=%0d stb=%b z=%h flags=%b required 1 4008000000000000 000",
                 i, z64_stb, z64, fl64);
      end
      @(negedge clk);
    end
    recv_z(0, z, fl, ok_z);
    checks++;
    if (!ok_z || z !== 64'h4008000000000000) begin
      errors++;
      $display("[TB] FAIL bp_release ok=%0d z=%h required 4008000000000000", ok_z, z);
    end
  endtask

  task automatic test_reset_in_align();
    logic [63:0] z; logic [2:0] fl; bit ok_a, ok_b, ok;
    send_a(0, 64'h3FF0000000000000, ok_a);
    send_b(0, 64'h3D70000000000000, 1'b0, ok_b);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (!(ok_a && ok_b) || z64_stb !== 1'b0 || a64_ack !== 1'b0 || z64 !== 64'h0) begin
      errors++;
      $display("[TB] FAIL align_reset_state ok=%0d stb=%b ack_a=%b z=%h required 1 0 0 0",
               ok_a & ok_b, z64_stb, a64_ack, z64);
    end
    @(negedge clk);
    checks++;
    if (a64_ack !== 1'b1 || z64_stb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL align_reset_ack ack_a=%b stb=%b required 1 0", a64_ack, z64_stb);
    end
    run_op(0, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, z, fl, ok);
    checks++;
    if (!ok || z !== 64'h4008000000000000 || fl !== 3'b000) begin
      errors++;
      $display("[TB] FAIL align_reset_recover ok=%0d z=%h flags=%b required 4008000000000000 000", ok, z, fl);
    end
  endtask

  initial begin
    rst = 1'b1;
    a64 = '0; b64 = '0; a64_stb = 1'b0; b64_stb = 1'b0; op64 = 1'b0; z64_ack = 1'b0;
    a32 = '0; b32 = '0; a32_stb = 1'b0; b32_stb = 1'b0; op32 = 1'b0; z32_ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_add_basic();
    test_zero_sign();
    test_overflow();
    test_special();
    test_single();
    test_backpressure();
    test_reset_in_align();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
